ifetch: RTL and testbench
=========================

# ifetch

Instruction-fetch sequencer between the program counter and instruction memory in the single-cycle RISC-V core. It requests the word at the current PC over a ren/ack handshake, captures the returned instruction and emits a one-cycle `iready` pulse that lets the PC advance and the rest of the datapath commit. It also supports a halt request, a wait-state timeout fault and a retired-instruction counter.

## Interface
Parameters:
- `WAIT_MAX`, default 16: maximum cycles in REQ without `imem_ack` before faulting; 0 disables the timeout.
- `NOP_WORD`, default 32'h00000013: value of `instr` out of reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `PCaddr`  in  32  current PC from the PC register; changes only on the edge that ends an `iready` cycle.
- `halt`  in  1  stop fetching after the current transaction completes.
- `imem_ren`  out  1  read request to instruction memory.
- `imem_addr`  out  32  read address; equals `PCaddr` whenever `imem_ren`=1.
- `imem_rdata`  in  32  read data; sampled only when `imem_ack`=1 in REQ.
- `imem_ack`  in  1  read complete this cycle.
- `instr`  out  32  registered instruction for decode.
- `iready`  out  1  one-cycle pulse: `instr` is valid and the PC may advance.
- `halted`  out  1  high in HALT.
- `ifault`  out  1  sticky fault flag: timeout, or misalignment when that check is compiled in.
- `icount`  out  32  count of `iready` pulses since reset.

## Operation
- States: IDLE, REQ, DONE, HALT, FAULT.
- Reset values: state=IDLE, `instr`=`NOP_WORD`, `icount`=0, `ifault`=0, wait counter=0. Outputs `imem_ren`, `iready` and `halted` are decoded from state, so they are 0.
- IDLE: go to REQ on the next edge, or to HALT if `halt`=1.
- REQ: `imem_ren`=1 and `imem_addr`=`PCaddr`.
  - If `imem_ack`=1: capture `imem_rdata` into `instr`, clear the wait counter and go to DONE.
  - Otherwise increment the wait counter. If `WAIT_MAX`≠0 and the counter reaches `WAIT_MAX`, go to FAULT.
- DONE: `iready`=1 and `icount` increments (wraps 0xFFFFFFFF→0). Next state is HALT if `halt`=1, otherwise REQ.
- HALT: `halted`=1 and `imem_ren`=0. Leaves HALT only via reset.
- FAULT: `ifault`=1 and `imem_ren`=0. Leaves FAULT only via reset.
- `halt` asserted during REQ does not abort the read. The transaction completes through DONE and then enters HALT.
- `imem_ack` in any state other than REQ is ignored. `instr` holds its last captured value in all states except REQ-with-ack.
- `imem_addr` outside REQ equals `PCaddr`, but memory must not act on it.

## Timing
- Fastest case: ack in the first REQ cycle. `iready` is high in the following cycle, giving 2 cycles per instruction.
- With N wait cycles before ack: REQ lasts N+1 cycles, then 1 cycle of DONE.
- The PC register updates on the edge ending DONE. The new `PCaddr` is therefore already stable during the first cycle of the next REQ.
- First fetch after reset release: IDLE for 1 cycle, then REQ at address `INITPC`.
- Timeout: FAULT is entered on the edge at which the count of ack-less REQ cycles equals `WAIT_MAX`.
- Reset asserted mid-transaction: every register returns to its reset value immediately (asynchronous). `imem_ren` drops without waiting for ack, and a late ack is ignored.

## Configuration
- Macro `IFETCH_ALIGN_CHK_EN`.
- Defined: on entry to REQ, if `PCaddr[1:0]`≠0, the block issues no read (`imem_ren` stays 0) and goes to FAULT on the next edge, with `icount` unchanged.
- Undefined: the alignment check is removed. Misaligned addresses are sent to memory unchanged, and `ifault` can come only from timeout.

## Test plan
- Reset release with `INITPC`=0 and ack the same cycle with `imem_rdata`=0x00500093 → `imem_addr`=0 while `imem_ren`=1; one cycle later `iready`=1, `instr`=0x00500093, `icount`=1.
- Memory with 3 wait states, 4 sequential fetches → each REQ lasts 4 cycles; exactly 4 `iready` pulses spaced 5 cycles apart; addresses 0, 4, 8, 12; `icount`=4.
- `halt` raised in the 2nd REQ cycle of a fetch with ack on the 3rd → `iready` pulses once, then `halted`=1 and `imem_ren`=0 permanently; `icount` is frozen.
- `WAIT_MAX`=4 and ack never asserted → `ifault`=1 after 4 REQ cycles, `imem_ren`=0, `iready` never pulses; `nRST` low then high recovers to IDLE with `ifault`=0.
- `nRST` pulsed low mid-REQ with ack arriving 1 cycle later → `instr`=0x00000013, `icount`=0, ack ignored, new fetch from `INITPC`.
- With `IFETCH_ALIGN_CHK_EN` defined, `PCaddr`=0x00000006 → no `imem_ren`, `ifault`=1. Without the macro, the same stimulus issues a read at 0x00000006.

Source files
------------

// File: rtl/ifetch.sv
// ============================================================================
// Module      : ifetch
// Description : Instruction-fetch sequencer (ren/ack handshake, halt, timeout
//               fault, retired-instruction counter). Optional misalignment
//               fault compiled in with IFETCH_ALIGN_CHK_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ifetch #(
    parameter int          WAIT_MAX = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] PCaddr,
    input  logic        halt,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic        iready,
    output logic        halted,
    output logic        ifault,
    output logic [31:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DONE  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [31:0] c_wait_max = 32'(WAIT_MAX);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_wait_cnt;
    logic        w_capture;
    logic        w_wait_inc;
    logic        w_misaligned;

`ifdef IFETCH_ALIGN_CHK_EN
    assign w_misaligned = (PCaddr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            instr      <= NOP_WORD;
            icount     <= '0;
        end else begin
            r_state <= w_next;
            // Counting on the capture edge makes icount already include the
            // instruction being presented while iready is high.
            if (w_capture) begin
                instr      <= imem_rdata;
                icount     <= icount + 32'd1;
                r_wait_cnt <= '0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        imem_ren   = 1'b0;
        w_capture  = 1'b0;
        w_wait_inc = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = halt ? S_HALT : S_REQ;
            S_REQ: begin
                if (w_misaligned) begin
                    w_next = S_FAULT;
                end else begin
                    imem_ren = 1'b1;
                    if (imem_ack) begin
                        w_capture = 1'b1;
                        w_next    = S_DONE;
                    end else begin
                        w_wait_inc = 1'b1;
                        if ((c_wait_max != 32'd0) && (r_wait_cnt + 32'd1 == c_wait_max))
                            w_next = S_FAULT;
                    end
                end
            end
            S_DONE:  w_next = halt ? S_HALT : S_REQ;
            S_HALT:  w_next = S_HALT;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    assign imem_addr = PCaddr;
    assign iready    = (r_state == S_DONE);
    assign halted    = (r_state == S_HALT);
    assign ifault    = (r_state == S_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module      : tb_ifetch
// Description : Self-checking bench for ifetch with a scoreboard of captured
//               instructions and retired counts.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch;

    localparam int          WAIT_MAX = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] PCaddr = '0;
    logic        halt = 1'b0;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr;
    logic        iready;
    logic        halted;
    logic        ifault;
    logic [31:0] icount;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc;
    logic [31:0] exp_count;
    logic [31:0] last_instr;

    ifetch #(.WAIT_MAX(WAIT_MAX), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .PCaddr     (PCaddr),
        .halt       (halt),
        .imem_ren   (imem_ren),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .iready     (iready),
        .halted     (halted),
        .ifault     (ifault),
        .icount     (icount)
    );

    always #5 clk = ~clk;

    // Leaves the DUT at a negedge inside its first REQ cycle.
    task automatic apply_reset(input logic [31:0] init_pc);
        @(negedge clk);
        nRST = 1'b0; halt = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        pc = init_pc; PCaddr = init_pc; exp_count = '0; sb.delete();
        @(negedge clk);
        checks++;
        if (instr !== NOP || icount !== 32'd0 || ifault !== 1'b0 || imem_ren !== 1'b0 ||
            iready !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: instr=%h icount=%0d ifault=%b ren=%b iready=%b halted=%b, required instr=%h icount=0 ifault=0 ren=0 iready=0 halted=0",
                     instr, icount, ifault, imem_ren, iready, halted, NOP);
        end
        nRST = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge inside REQ; returns at the negedge after DONE.
    task automatic fetch(input int waits, input logic [31:0] data, input int halt_at);
        exp_t e;
        for (int k = 0; k <= waits; k++) begin
            if (k == halt_at) halt = 1'b1;
            checks++;
            if (imem_ren !== 1'b1 || imem_addr !== pc || iready !== 1'b0 || ifault !== 1'b0) begin
                errors++;
                $display("FAIL req_cycle%0d: ren=%b addr=%h iready=%b ifault=%b, required ren=1 addr=%h iready=0 ifault=0",
                         k, imem_ren, imem_addr, iready, ifault, pc);
            end
            if (k == waits) begin
                imem_ack = 1'b1; imem_rdata = data;
                exp_count = exp_count + 32'd1;
                sb.push_back('{data, exp_count});
            end else begin
                imem_ack = 1'b0; imem_rdata = $urandom;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0; imem_rdata = $urandom;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL done_cycle: scoreboard empty, required one pending entry");
        end else begin
            e = sb.pop_front();
            if (iready !== 1'b1 || instr !== e.ins || icount !== e.cnt || imem_ren !== 1'b0) begin
                errors++;
                $display("FAIL done_cycle: iready=%b instr=%h icount=%0d ren=%b, required iready=1 instr=%h icount=%0d ren=0",
                         iready, instr, icount, imem_ren, e.ins, e.cnt);
            end
            last_instr = e.ins;
        end
        pc = pc + 32'd4; PCaddr = pc;
        @(negedge clk);
    endtask

    task automatic test_reset;
        apply_reset(32'd0);
    endtask

    task automatic test_first_fetch;
        apply_reset(32'd0);
        fetch(0, 32'h0050_0093, -1);
    endtask

    task automatic test_wait_states;
        apply_reset(32'd0);
        for (int i = 0; i < 4; i++) fetch(3, $urandom, -1);
        checks++;
        if (icount !== 32'd4 || exp_count !== 32'd4 || imem_addr !== 32'd16) begin
            errors++;
            $display("FAIL wait_states_total: icount=%0d addr=%h, required icount=4 addr=00000010", icount, imem_addr);
        end
    endtask

    task automatic test_halt;
        apply_reset(32'd0);
        fetch(0, 32'h0010_0113, -1);
        fetch(2, 32'h0020_0193, 1);
        for (int c = 0; c < 6; c++) begin
            if (c == 3) halt = 1'b0;
            imem_ack = 1'b1; imem_rdata = $urandom;
            checks++;
            if (halted !== 1'b1 || imem_ren !== 1'b0 || iready !== 1'b0 ||
                icount !== exp_count || instr !== last_instr) begin
                errors++;
                $display("FAIL halt_cycle%0d: halted=%b ren=%b iready=%b icount=%0d instr=%h, required halted=1 ren=0 iready=0 icount=%0d instr=%h",
                         c, halted, imem_ren, iready, icount, instr, exp_count, last_instr);
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_timeout;
        apply_reset(32'd0);
        for (int k = 0; k < WAIT_MAX; k++) begin
            checks++;
            if (imem_ren !== 1'b1 || ifault !== 1'b0) begin
                errors++;
                $display("FAIL timeout_req%0d: ren=%b ifault=%b, required ren=1 ifault=0", k, imem_ren, ifault);
            end
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ifault !== 1'b1 || imem_ren !== 1'b0 || iready !== 1'b0 || icount !== 32'd0) begin
                errors++;
                $display("FAIL timeout_fault%0d: ifault=%b ren=%b iready=%b icount=%0d, required ifault=1 ren=0 iready=0 icount=0",
                         c, ifault, imem_ren, iready, icount);
            end
            @(negedge clk);
        end
        apply_reset(32'd0);
        fetch(WAIT_MAX - 1, 32'h0030_0213, -1);
    endtask

    task automatic test_reset_mid_req;
        apply_reset(32'd0);
        fetch(0, 32'hABCD_0293, -1);
        @(negedge clk);
        nRST = 1'b0;
        #1;
        checks++;
        if (imem_ren !== 1'b0 || instr !== NOP || icount !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: ren=%b instr=%h icount=%0d, required ren=0 instr=%h icount=0",
                     imem_ren, instr, icount, NOP);
        end
        pc = 32'd0; PCaddr = 32'd0; exp_count = '0; sb.delete();
        @(negedge clk);
        nRST = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (instr !== NOP || icount !== 32'd0) begin
            errors++;
            $display("FAIL late_ack: instr=%h icount=%0d, required instr=%h icount=0", instr, icount, NOP);
        end
        fetch(1, 32'h0040_0313, -1);
    endtask

    task automatic test_alignment;
        apply_reset(32'h0000_0006);
`ifdef IFETCH_ALIGN_CHK_EN
        checks++;
        if (imem_ren !== 1'b0) begin
            errors++;
            $display("FAIL align_no_read: ren=%b, required ren=0", imem_ren);
        end
        @(negedge clk);
        checks++;
        if (ifault !== 1'b1 || imem_ren !== 1'b0 || icount !== 32'd0) begin
            errors++;
            $display("FAIL align_fault: ifault=%b ren=%b icount=%0d, required ifault=1 ren=0 icount=0",
                     ifault, imem_ren, icount);
        end
`else
        fetch(0, 32'h0050_0393, -1);
`endif
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_wait_states;
        test_halt;
        test_timeout;
        test_reset_mid_req;
        test_alignment;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
